// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with a valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating bubble counter. State moves on the falling edge.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              valid_d,
    output logic              ready_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data1_d,
    input  logic [DATA_W-1:0] data2_d,
    input  logic [REG_W-1:0]  rs_d,
    input  logic [REG_W-1:0]  rt_d,
    input  logic [REG_W-1:0]  rd_d,
    input  logic [DATA_W-1:0] imm_d,
    output logic              valid_e,
    input  logic              ready_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [DATA_W-1:0] data1_e,
    output logic [DATA_W-1:0] data2_e,
    output logic [REG_W-1:0]  rs_e,
    output logic [REG_W-1:0]  rt_e,
    output logic [REG_W-1:0]  rd_e,
    output logic [DATA_W-1:0] imm_e,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] imm;
    } entry_t;

    entry_t in_ent;
    entry_t main_q;
    entry_t skid_q;
    logic   valid_q;
    logic   skid_v;
    logic   accept;
    logic   advance;

    assign in_ent.ctrl  = ctrl_d;
    assign in_ent.data1 = data1_d;
    assign in_ent.data2 = data2_d;
    assign in_ent.rs    = rs_d;
    assign in_ent.rt    = rt_d;
    assign in_ent.rd    = rd_d;
    assign in_ent.imm   = imm_d;

    // ready_d comes straight from a flop: no path from ready_e
    assign ready_d = !skid_v;
    assign accept  = valid_d && !skid_v;
    assign advance = !valid_q || ready_e;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            valid_q    <= 1'b0;
            skid_v     <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            if (ready_e && !valid_q && bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + 1'b1;

            if (flush) begin
                valid_q     <= 1'b0;
                skid_v      <= 1'b0;
                main_q.ctrl <= '0;
                skid_q.ctrl <= '0;
            end else if (advance) begin
                if (skid_v) begin
                    main_q      <= skid_q;
                    valid_q     <= 1'b1;
                    skid_v      <= 1'b0;
                    skid_q.ctrl <= '0;
                end else if (accept) begin
                    main_q  <= in_ent;
                    valid_q <= 1'b1;
                end else begin
                    valid_q     <= 1'b0;
                    main_q.ctrl <= '0;
                end
            end else if (accept) begin
                skid_q <= in_ent;
                skid_v <= 1'b1;
            end
        end
    end

    assign valid_e = valid_q;
    assign ctrl_e  = main_q.ctrl;
    assign data1_e = main_q.data1;
    assign data2_e = main_q.data2;
    assign rs_e    = main_q.rs;
    assign rt_e    = main_q.rt;
    assign rd_e    = main_q.rd;
    assign imm_e   = main_q.imm;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, bubble counter,
// async reset during a stall and a random-backpressure scoreboard.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_d;
    logic        ready_d;
    logic [10:0] ctrl_d;
    logic [31:0] data1_d, data2_d, imm_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic        valid_e;
    logic        ready_e;
    logic [10:0] ctrl_e;
    logic [31:0] data1_e, data2_e, imm_e;
    logic [4:0]  rs_e, rt_e, rd_e;
    logic [15:0] bubble_cnt;

    logic        s_ready_d, s_valid_e;
    logic [10:0] s_ctrl_e;
    logic [31:0] s_data1_e, s_data2_e, s_imm_e;
    logic [4:0]  s_rs_e, s_rt_e, s_rd_e;
    logic [3:0]  s_bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .valid_d(valid_d), .ready_d(ready_d), .ctrl_d(ctrl_d),
        .data1_d(data1_d), .data2_d(data2_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .imm_d(imm_d),
        .valid_e(valid_e), .ready_e(ready_e), .ctrl_e(ctrl_e),
        .data1_e(data1_e), .data2_e(data2_e),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .imm_e(imm_e),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .valid_d(valid_d), .ready_d(s_ready_d), .ctrl_d(ctrl_d),
        .data1_d(data1_d), .data2_d(data2_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .imm_d(imm_d),
        .valid_e(s_valid_e), .ready_e(ready_e), .ctrl_e(s_ctrl_e),
        .data1_e(s_data1_e), .data2_e(s_data2_e),
        .rs_e(s_rs_e), .rt_e(s_rt_e), .rd_e(s_rd_e), .imm_e(s_imm_e),
        .bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        logic        vd, re, fl;
        logic [10:0] ctrl;
        logic [31:0] d1;
        logic [4:0]  rd;
        logic        ev, er;
        logic [10:0] ec;
        logic [31:0] ed;
        logic [4:0]  erd;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] c, input logic [31:0] d1, input logic [4:0] rd);
        ctrl_d  = c;
        data1_d = d1;
        data2_d = ~d1;
        imm_d   = d1 ^ 32'h5A5A_5A5A;
        rd_d    = rd;
        rs_d    = rd + 5'd1;
        rt_d    = rd ^ 5'h15;
    endtask

    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic vd, logic re, logic fl, logic [10:0] c,
                                logic [31:0] d1, logic [4:0] rd, logic ev, logic er,
                                logic [10:0] ec, logic [31:0] ed, logic [4:0] erd);
        vec_t v;
        v.vd = vd; v.re = re; v.fl = fl; v.ctrl = c; v.d1 = d1; v.rd = rd;
        v.ev = ev; v.er = er; v.ec = ec; v.ed = ed; v.erd = erd;
        return v;
    endfunction

    int unsigned q[$];
    int sent, recv, cyc_n;
    logic [31:0] exp_d;
    logic [4:0]  r5;

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_d = 1'b0; ready_e = 1'b0;
        drive(11'h0, 32'h0, 5'd0);

        @(posedge clk); #1;
        chk("rst_valid_e", 64'(valid_e), 64'(0));
        chk("rst_ready_d", 64'(ready_d), 64'(1));
        chk("rst_payload", 64'({ctrl_e, rd_e, rs_e, rt_e} | 64'(data1_e | data2_e | imm_e)), 64'(0));
        chk("rst_bubble", 64'(bubble_cnt), 64'(0));
        cyc();
        rst_n = 1'b1;

        ready_e = 1'b1;
        repeat (5) cyc();
        chk("bubble_5", 64'(bubble_cnt), 64'(5));
        repeat (15) cyc();
        chk("bubble_20", 64'(bubble_cnt), 64'(20));
        chk("bubble_sat4", 64'(s_bubble_cnt), 64'(15));

        vt[0]  = mk(1,1,0,11'h401,32'h1,5'd1,          1,1,11'h401,32'h1,5'd1);
        vt[1]  = mk(1,1,0,11'h402,32'h2,5'd2,          1,1,11'h402,32'h2,5'd2);
        vt[2]  = mk(1,1,0,11'h403,32'h3,5'd3,          1,1,11'h403,32'h3,5'd3);
        vt[3]  = mk(1,1,0,11'h404,32'h4,5'd4,          1,1,11'h404,32'h4,5'd4);
        vt[4]  = mk(0,1,0,11'h0,32'h0,5'd0,            0,1,11'h0,32'h4,5'd4);
        vt[5]  = mk(1,1,0,11'h155,32'hAAAA_0001,5'd10, 1,1,11'h155,32'hAAAA_0001,5'd10);
        vt[6]  = mk(1,0,0,11'h2AA,32'hBBBB_0002,5'd11, 1,0,11'h155,32'hAAAA_0001,5'd10);
        vt[7]  = mk(1,0,0,11'h333,32'hCCCC_0003,5'd12, 1,0,11'h155,32'hAAAA_0001,5'd10);
        vt[8]  = mk(0,1,0,11'h0,32'h0,5'd0,            1,1,11'h2AA,32'hBBBB_0002,5'd11);
        vt[9]  = mk(0,1,0,11'h0,32'h0,5'd0,            0,1,11'h0,32'hBBBB_0002,5'd11);
        vt[10] = mk(1,0,0,11'h0F0,32'hD,5'd13,         1,1,11'h0F0,32'hD,5'd13);
        vt[11] = mk(1,0,0,11'h111,32'hE,5'd14,         1,0,11'h0F0,32'hD,5'd13);
        vt[12] = mk(1,0,1,11'h7FF,32'hFFFF_FFFF,5'd31, 0,1,11'h0,32'hD,5'd13);
        vt[13] = mk(0,1,0,11'h0,32'h0,5'd0,            0,1,11'h0,32'hD,5'd13);
        vt[14] = mk(1,1,0,11'h0AA,32'hF,5'd15,         1,1,11'h0AA,32'hF,5'd15);
        vt[15] = mk(1,1,1,11'h7FF,32'hFFFF_FFFF,5'd31, 0,1,11'h0,32'hF,5'd15);
        vt[16] = mk(0,1,0,11'h0,32'h0,5'd0,            0,1,11'h0,32'hF,5'd15);

        for (int i = 0; i < 17; i++) begin
            valid_d = vt[i].vd; ready_e = vt[i].re; flush = vt[i].fl;
            drive(vt[i].ctrl, vt[i].d1, vt[i].rd);
            cyc();
            chk($sformatf("v%0d_valid_e", i), 64'(valid_e), 64'(vt[i].ev));
            chk($sformatf("v%0d_ready_d", i), 64'(ready_d), 64'(vt[i].er));
            chk($sformatf("v%0d_ctrl_e", i), 64'(ctrl_e), 64'(vt[i].ec));
            chk($sformatf("v%0d_data1_e", i), 64'(data1_e), 64'(vt[i].ed));
            chk($sformatf("v%0d_rd_e", i), 64'(rd_e), 64'(vt[i].erd));
            r5 = vt[i].erd + 5'd1;
            chk($sformatf("v%0d_aux", i), {data2_e, rs_e, rt_e, imm_e[21:0]},
                {~vt[i].ed, r5, vt[i].erd ^ 5'h15, vt[i].ed[21:0] ^ 22'h1A_5A5A});
        end
        flush = 1'b0;

        // fill main and skid, then pull reset between edges
        valid_d = 1'b1; ready_e = 1'b0;
        drive(11'h321, 32'h1111_0001, 5'd7);
        cyc();
        drive(11'h322, 32'h2222_0002, 5'd8);
        cyc();
        valid_d = 1'b0;
        chk("pre_arst_ready_d", 64'(ready_d), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_e", 64'(valid_e), 64'(0));
        chk("arst_ready_d", 64'(ready_d), 64'(1));
        chk("arst_payload", 64'({ctrl_e, rd_e, rs_e, rt_e} | 64'(data1_e | data2_e | imm_e)), 64'(0));
        chk("arst_bubble", 64'(bubble_cnt), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // random backpressure, 200 entries, Decode holds payload until accepted
        sent = 0; recv = 0; cyc_n = 0;
        valid_d = 1'b0;
        while ((sent < 200 || q.size() != 0) && cyc_n < 3000) begin
            if (!valid_d && sent < 200 && $urandom_range(3) != 0) begin
                valid_d = 1'b1;
                drive(11'h400 | 11'(sent & 10'h3FF), 32'hC0DE_0000 | 32'(sent), 5'(sent));
            end
            ready_e = 1'($urandom_range(1));
            if (valid_e && ready_e) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", 64'(data1_e), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_d = q.pop_front();
                    chk("sb_data1", 64'(data1_e), 64'(exp_d));
                    chk("sb_rd", 64'(rd_e), 64'(exp_d[4:0]));
                    recv++;
                end
            end
            if (!valid_e) chk("sb_bubble_ctrl", 64'(ctrl_e), 64'(0));
            if (valid_d && ready_d) begin
                q.push_back(data1_d);
                sent++;
            end
            cyc();
            if (valid_d && ready_d && q.size() != 0 && q[q.size()-1] == data1_d)
                valid_d = 1'b0;
            cyc_n++;
        end
        chk("sb_received", 64'(recv), 64'(200));
        chk("sb_drained", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
